store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
Sits directly downstream of the single-cycle RV32 core's data-memory port. Captures each store (write enable, address, data) into a small FIFO in the cycle it is issued. Drains entries in order to the data-memory bus over a valid/ready handshake, so the core never waits on memory write latency. Exports a stall request for when the FIFO cannot accept a store.

Parameters:
XLEN, 32, data/address width; must match core XLEN
DEPTH, 4, number of buffered stores; power of two, >= 2

Ports:
clk  input  1  clock
n_rst  input  1  reset, synchronous, active-low
core_write_enable  input  1  store issued this cycle
core_address  input  XLEN  store/load byte address from core
core_write_data  input  XLEN  store data from core
core_read_data  output  XLEN  load data returned to core
stall  output  1  store cannot be accepted this cycle
overflow  output  1  sticky: a store was dropped
occupancy  output  $clog2(DEPTH)+1  entries currently held
bus_valid  output  1  head entry presented to memory
bus_ready  input  1  memory accepts head entry
bus_address  output  XLEN  head entry address
bus_write_data  output  XLEN  head entry data
bus_read_data  input  XLEN  raw memory read data for loads

Behaviour:
- Storage: DEPTH entries {address, data}; read/write pointers $clog2(DEPTH)+1 bits wide (extra wrap bit); full = pointers differ only in MSB; empty = pointers equal; occupancy = wr_ptr - rd_ptr.
- pop = bus_valid && bus_ready. push = core_write_enable && (!full || pop).
- Full with simultaneous pop: store accepted; occupancy stays DEPTH.
- stall = core_write_enable && full && !bus_ready; combinational.
- Store arriving while stall is high is dropped: nothing is written, pointers unchanged, overflow set on the next edge. overflow stays set until reset.
- Push and pop in the same cycle: both pointers advance; occupancy unchanged.
- Empty with simultaneous push: entry is written. bus_valid rises the next cycle (no bypass; minimum store-to-bus latency is 1 cycle).
- bus_valid = !empty. bus_address and bus_write_data come from the head entry and are stable while bus_valid && !bus_ready.
- Address bits pass through unmodified; no alignment checking.
- Pointers wrap modulo 2*DEPTH via natural overflow.
- Entries drain strictly in FIFO order.
- Reset (any time, including mid-drain): pointers = 0, overflow = 0, so bus_valid = 0, occupancy = 0, stall = 0. Entry contents need not be cleared. Buffered stores are discarded.
- core_read_data: see Optional Feature.

Optional Feature:
STORE_BUFFER_FORWARD_EN
- Defined: core_read_data = data of the youngest valid entry whose address equals core_address (full XLEN compare); otherwise bus_read_data. The head entry being popped this cycle still participates. A store being pushed this cycle does not forward. Forwarding is combinational, with zero added latency.
- Undefined: core_read_data = bus_read_data; no compare logic is generated.

Decomposition:
- riscv_pkg: add STORE_BUFFER_DEPTH (default 4) constant.
- Entry struct typedef stays local to the module because it depends on XLEN.
- One sub-module, store_buffer_forward: takes the entry array, valid mask, head/tail pointers and lookup address, and returns hit plus data using youngest-first priority. It is instantiated only under STORE_BUFFER_FORWARD_EN.

Test Plan:
- Reset, then single store addr 0x100 data 0xDEADBEEF with bus_ready=1 -> bus_valid high next cycle with 0x100/0xDEADBEEF; occupancy 1 then 0.
- bus_ready=0, 4 stores 0x0,0x4,0x8,0xC -> occupancy 4, stall=0 throughout. Fifth store -> stall=1, dropped, overflow=1. Release ready -> exactly 4 bus beats in order.
- Full, bus_ready=1, store 0x10 same cycle -> accepted, stall=0, occupancy stays 4; 0x10 appears as 5th beat.
- bus_ready toggling 1/0 with continuous stores across more than 2*DEPTH pushes -> every address appears once in order (pointer wrap); bus outputs stable while stalled.
- Forward enabled: stores 0x20=1 then 0x20=2 held with bus_ready=0, load 0x20 with bus_read_data=0xFF -> core_read_data=2. Load 0x24 -> 0xFF. Forward disabled -> 0xFF for both.
- Assert n_rst with 3 entries pending -> next cycle bus_valid=0, occupancy=0, overflow=0; no stale beat after reset release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the RV32 core slice.
package riscv_pkg;

   localparam int STORE_BUFFER_DEPTH = 4;

endpackage

// File: rtl/store_buffer_forward.sv
// Store-to-load forwarding lookup: returns the youngest buffered store whose
// address matches the lookup address.
module store_buffer_forward #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0][XLEN-1:0] entry_address,
   input  logic [DEPTH-1:0][XLEN-1:0] entry_data,
   input  logic [DEPTH-1:0]           entry_valid,
   input  logic [$clog2(DEPTH):0]     head_ptr,
   input  logic [$clog2(DEPTH):0]     tail_ptr,
   input  logic [XLEN-1:0]            lookup_address,
   output logic                       hit,
   output logic [XLEN-1:0]            hit_data
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   logic [PW-1:0] count;
   logic [IW-1:0] idx;

   // Walk oldest to youngest so a later (younger) match overrides an older one.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      count    = tail_ptr - head_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_ptr[IW-1:0] + IW'(k);
         if ((PW'(k) < count) && entry_valid[idx] &&
             (entry_address[idx] == lookup_address)) begin
            hit      = 1'b1;
            hit_data = entry_data[idx];
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO between the core data port and the memory bus.
// Optional store-to-load forwarding is enabled by defining STORE_BUFFER_FORWARD_EN.
module store_buffer
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = STORE_BUFFER_DEPTH
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     core_write_enable,
   input  logic [XLEN-1:0]          core_address,
   input  logic [XLEN-1:0]          core_write_data,
   output logic [XLEN-1:0]          core_read_data,
   output logic                     stall,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     bus_valid,
   input  logic                     bus_ready,
   output logic [XLEN-1:0]          bus_address,
   output logic [XLEN-1:0]          bus_write_data,
   input  logic [XLEN-1:0]          bus_read_data
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam logic [PW-1:0] WRAP_BIT = PW'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] address;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t        entries [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   // The extra pointer bit separates full from empty when the indices coincide.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = ((wr_ptr ^ rd_ptr) == WRAP_BIT);
   assign occupancy = wr_ptr - rd_ptr;

   assign bus_valid      = !empty;
   assign bus_address    = entries[rd_ptr[IW-1:0]].address;
   assign bus_write_data = entries[rd_ptr[IW-1:0]].data;

   assign pop   = bus_valid && bus_ready;
   assign push  = core_write_enable && (!full || pop);
   assign stall = core_write_enable && full && !bus_ready;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (core_write_enable && !push)
            overflow <= 1'b1;
      end
   end

   // Entry storage carries no reset; only the pointers define what is live.
   always_ff @(posedge clk) begin
      if (push)
         entries[wr_ptr[IW-1:0]] <= '{address: core_address, data: core_write_data};
   end

`ifdef STORE_BUFFER_FORWARD_EN
   logic [DEPTH-1:0][XLEN-1:0] flat_address;
   logic [DEPTH-1:0][XLEN-1:0] flat_data;
   logic [DEPTH-1:0]           entry_valid;
   logic [IW-1:0]              offset;
   logic                       fwd_hit;
   logic [XLEN-1:0]            fwd_data;

   always_comb begin
      flat_address = '0;
      flat_data    = '0;
      entry_valid  = '0;
      offset       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         flat_address[i] = entries[i].address;
         flat_data[i]    = entries[i].data;
         offset          = IW'(i) - rd_ptr[IW-1:0];
         entry_valid[i]  = ({1'b0, offset} < occupancy);
      end
   end

   store_buffer_forward #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH)
   ) u_forward (
      .entry_address  (flat_address),
      .entry_data     (flat_data),
      .entry_valid    (entry_valid),
      .head_ptr       (rd_ptr),
      .tail_ptr       (wr_ptr),
      .lookup_address (core_address),
      .hit            (fwd_hit),
      .hit_data       (fwd_data)
   );

   assign core_read_data = fwd_hit ? fwd_data : bus_read_data;
`else
   logic unused_address;

   assign unused_address = ^core_address;
   assign core_read_data = bus_read_data;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model plus
// directed literal expectations. Honours STORE_BUFFER_FORWARD_EN.
module tb_store_buffer;

   localparam int W = 32;
   localparam int D = 4;

`ifdef STORE_BUFFER_FORWARD_EN
   localparam bit FwdEn = 1'b1;
`else
   localparam bit FwdEn = 1'b0;
`endif

   logic          clk;
   logic          n_rst;
   logic          core_write_enable;
   logic [W-1:0]  core_address;
   logic [W-1:0]  core_write_data;
   logic [W-1:0]  core_read_data;
   logic          stall;
   logic          overflow;
   logic [2:0]    occupancy;
   logic          bus_valid;
   logic          bus_ready;
   logic [W-1:0]  bus_address;
   logic [W-1:0]  bus_write_data;
   logic [W-1:0]  bus_read_data;

   store_buffer #(
      .XLEN  (W),
      .DEPTH (D)
   ) dut (
      .clk               (clk),
      .n_rst             (n_rst),
      .core_write_enable (core_write_enable),
      .core_address      (core_address),
      .core_write_data   (core_write_data),
      .core_read_data    (core_read_data),
      .stall             (stall),
      .overflow          (overflow),
      .occupancy         (occupancy),
      .bus_valid         (bus_valid),
      .bus_ready         (bus_ready),
      .bus_address       (bus_address),
      .bus_write_data    (bus_write_data),
      .bus_read_data     (bus_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] d;
   } ent_t;

   ent_t         mq[$];
   logic [W-1:0] beats[$];
   logic [W-1:0] expect_list[$];
   bit           m_overflow;
   bit           hold_prev;
   logic [W-1:0] prev_addr;
   logic [W-1:0] prev_data;
   int           errors = 0;
   int           checks = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Youngest matching store wins; otherwise memory data passes through.
   function automatic logic [W-1:0] modelRead(input logic [W-1:0] addr, input logic [W-1:0] raw);
      logic [W-1:0] r;
      r = raw;
      if (FwdEn) begin
         for (int i = 0; i < mq.size(); i++)
            if (mq[i].a == addr) r = mq[i].d;
      end
      return r;
   endfunction

   task automatic checkOutput();
      bit full_m;
      full_m = (mq.size() == D);
      check("bus_valid", W'(bus_valid), W'(mq.size() > 0));
      check("occupancy", W'(occupancy), W'(mq.size()));
      check("stall", W'(stall), W'(core_write_enable && full_m && !bus_ready));
      check("overflow", W'(overflow), W'(m_overflow));
      check("core_read_data", core_read_data, modelRead(core_address, bus_read_data));
      if (mq.size() > 0) begin
         check("bus_address", bus_address, mq[0].a);
         check("bus_write_data", bus_write_data, mq[0].d);
      end
      if (hold_prev) begin
         check("hold_address", bus_address, prev_addr);
         check("hold_data", bus_write_data, prev_data);
      end
      if (bus_valid && bus_ready && n_rst)
         beats.push_back(bus_address);
      hold_prev = bus_valid && !bus_ready && n_rst;
      prev_addr = bus_address;
      prev_data = bus_write_data;
   endtask

   task automatic updateModel();
      bit pop_m;
      bit push_m;
      if (!n_rst) begin
         mq.delete();
         m_overflow = 1'b0;
         hold_prev  = 1'b0;
      end else begin
         pop_m  = (mq.size() > 0) && bus_ready;
         push_m = core_write_enable && ((mq.size() < D) || pop_m);
         if (pop_m) void'(mq.pop_front());
         if (push_m) mq.push_back('{a: core_address, d: core_write_data});
         if (core_write_enable && !push_m) m_overflow = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic rst_v, input logic we_v, input logic [W-1:0] a,
                                input logic [W-1:0] d, input logic rdy, input logic [W-1:0] rd);
      @(negedge clk);
      n_rst             = rst_v;
      core_write_enable = we_v;
      core_address      = a;
      core_write_data   = d;
      bus_ready         = rdy;
      bus_read_data     = rd;
      #1 checkOutput();
      @(posedge clk);
      updateModel();
   endtask

   task automatic loadCheck(input string name, input logic [W-1:0] a, input logic [W-1:0] lit);
      @(negedge clk);
      n_rst             = 1'b1;
      core_write_enable = 1'b0;
      core_address      = a;
      core_write_data   = '0;
      bus_ready         = 1'b0;
      bus_read_data     = 32'hFF;
      #1;
      check(name, core_read_data, lit);
      checkOutput();
      @(posedge clk);
      updateModel();
   endtask

   initial begin
      n_rst             = 1'b0;
      core_write_enable = 1'b0;
      core_address      = '0;
      core_write_data   = '0;
      bus_ready         = 1'b0;
      bus_read_data     = '0;
      m_overflow        = 1'b0;
      hold_prev         = 1'b0;

      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      #1;
      check("reset_occupancy", W'(occupancy), 0);
      check("reset_valid", W'(bus_valid), 0);

      // Single store, then drain.
      applyStimulus(1, 1, 32'h100, 32'hDEADBEEF, 1, 0);
      #1;
      check("t1_valid", W'(bus_valid), 1);
      check("t1_address", bus_address, 32'h100);
      check("t1_data", bus_write_data, 32'hDEADBEEF);
      check("t1_occ", W'(occupancy), 1);
      applyStimulus(1, 0, 0, 0, 1, 0);
      #1;
      check("t1_occ_after", W'(occupancy), 0);

      // Fill with memory stalled, drop a fifth store, then drain.
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 1, 32'(4 * i), 32'h1000 + 32'(i), 0, 0);
      #1;
      check("t2_occ_full", W'(occupancy), 4);
      applyStimulus(1, 1, 32'h30, 32'hBAD, 0, 0);
      #1;
      check("t2_overflow", W'(overflow), 1);
      check("t2_occ_kept", W'(occupancy), 4);
      beats.delete();
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 0, 0, 0, 1, 0);
      check("t2_beat_count", 32'(beats.size()), 4);
      for (int i = 0; i < 4 && i < beats.size(); i++)
         check("t2_beat_order", beats[i], 32'(4 * i));

      // Full with a simultaneous pop still accepts the store.
      for (int i = 0; i < 4; i++)
         applyStimulus(1, 1, 32'h40 + 32'(4 * i), 32'h2000 + 32'(i), 0, 0);
      beats.delete();
      applyStimulus(1, 1, 32'h10, 32'h2010, 1, 0);
      #1;
      check("t3_occ", W'(occupancy), 4);
      for (int i = 0; i < 5; i++)
         applyStimulus(1, 0, 0, 0, 1, 0);
      check("t3_beat_count", 32'(beats.size()), 5);
      if (beats.size() == 5)
         check("t3_fifth_beat", beats[4], 32'h10);

      // Continuous traffic with toggling ready: pointer wrap.
      beats.delete();
      expect_list.delete();
      for (int i = 0; i < 15; i++) begin
         if (i % 3 != 2) begin
            expect_list.push_back(32'h200 + 32'(4 * expect_list.size()));
            applyStimulus(1, 1, expect_list[expect_list.size() - 1], 32'h3000 + 32'(i), (i % 3 != 1), 0);
         end else begin
            applyStimulus(1, 0, 0, 0, (i % 3 != 1), 0);
         end
      end
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 0, 0, 0, 1, 0);
      check("t4_beat_count", 32'(beats.size()), 32'(expect_list.size()));
      for (int i = 0; i < expect_list.size() && i < beats.size(); i++)
         check("t4_beat_order", beats[i], expect_list[i]);

      // Forwarding.
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 32'h20, 32'h1, 0, 0);
      applyStimulus(1, 1, 32'h20, 32'h2, 0, 0);
      loadCheck("fwd_hit", 32'h20, FwdEn ? 32'h2 : 32'hFF);
      loadCheck("fwd_miss", 32'h24, 32'hFF);

      // Reset with three stores pending.
      applyStimulus(1, 1, 32'h60, 32'h6, 0, 0);
      #1;
      check("t6_occ_before", W'(occupancy), 3);
      applyStimulus(0, 0, 0, 0, 1, 0);
      #1;
      check("t6_valid", W'(bus_valid), 0);
      check("t6_occ", W'(occupancy), 0);
      check("t6_overflow", W'(overflow), 0);
      beats.delete();
      for (int i = 0; i < 3; i++)
         applyStimulus(1, 0, 0, 0, 1, 0);
      check("t6_no_stale_beat", 32'(beats.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
